ps2_note_encoder: RTL and testbench
===================================

Name: ps2_note_encoder

Overview:
Converts the PS/2 keyboard byte stream into note events for the synth's ALU controller.
It consumes one scan-code byte per strobe and drives the controller's note-event interface: note_in pulse, note, octave.
It tracks make and break (F0) prefixes, a selectable octave, and the currently held key.
It also produces a note_off pulse on release, to drive the release phase of the envelope.

Parameters:
DEFAULT_OCTAVE, 4, octave selected out of reset (octave 4 = middle C)
MAX_OCTAVE, 6, highest legal octave (7 octaves, 0..6)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
scan_code  in  8  PS/2 set-2 byte from the PS/2 receiver
scan_valid  in  1  one-cycle strobe, scan_code valid
note_in  out  1  one-cycle pulse: new note triggered
note  out  4  note of last trigger: 0=C,1=C#,...,11=B
octave  out  3  octave of last trigger
note_off  out  1  one-cycle pulse: held note released
key_held  out  1  a note key is currently held
oct_sel  out  3  currently selected octave (for HEX display)

Behaviour:
- Clocking and reset: one clock, clk. Asynchronous active-low reset, reset.
- Reset values: note_in=0, note_off=0, key_held=0, note=0, octave=DEFAULT_OCTAVE, oct_sel=DEFAULT_OCTAVE, held_code=0, FSM=IDLE.
- Processing: bytes are processed only on cycles with scan_valid=1. Back-to-back strobes on consecutive cycles are legal. All outputs are registered.
- FSM states: IDLE, BREAK, EXT, EXT_BREAK.
- IDLE transitions:
  - F0 -> BREAK.
  - E0 -> EXT.
  - Any other byte is a make code, handled per the key map, and the FSM stays in IDLE.
- BREAK: the next byte is a released code -> IDLE. If the code equals held_code and key_held=1, pulse note_off and clear key_held. Otherwise the byte is ignored.
- EXT: F0 -> EXT_BREAK; any other byte -> IDLE, ignored. Extended keys carry no function.
- EXT_BREAK: any byte -> IDLE, ignored.
- Key map, makes only:
  - Note keys: 1C=C, 1D=C#, 1B=D, 24=D#, 23=E, 2B=F, 2C=F#, 34=G, 35=G#, 33=A, 3C=A#, 3B=B.
  - 42 = C at oct_sel+1, saturated at MAX_OCTAVE.
  - 1A = octave down, 22 = octave up.
  - All other codes are ignored.
- Note make:
  - If key_held=1 and the code equals held_code, it is typematic repeat: no pulse, no change.
  - Otherwise pulse note_in one cycle after the strobe. Load note and octave in that same cycle, set key_held=1, and set held_code=code. This is last-note priority: a new key steals the voice without a note_off.
  - note and octave remain stable until the next note_in.
- Octave keys:
  - oct_sel is decremented or incremented, saturating at 0 and MAX_OCTAVE. No pulse is generated.
  - The change affects only subsequent triggers; the held note is not retriggered.
  - Typematic repeat of an octave key steps again, still saturating.
- Latency: exactly 1 cycle from the scan_valid of the deciding byte to the note_in or note_off pulse.
- Exclusivity: note_in and note_off never assert in the same cycle.
- Reset mid-sequence (e.g. after F0): returns to IDLE. A subsequent orphan code byte is then treated as a make.

Decomposition:
- Shared package ps2_synth_pkg holds:
  - scan-code constants (F0, E0, key codes);
  - note encodings C..B (0..11);
  - FSM state localparams;
  - the width constants NOTE_W=4 and OCT_W=3.
- One combinational sub-module, ps2_keymap:
  - input: scan_code;
  - outputs: is_note, note[3:0], oct_bump, is_oct_up, is_oct_down.
- ps2_note_encoder holds the FSM, held-key tracking, oct_sel saturation and the output registers.

Test Plan:
- Reset, then strobe 1C -> one cycle later note_in=1 for exactly one cycle, note=0, octave=4, key_held=1.
- After 1C, strobe 1C three more times (typematic) -> no further note_in. Then F0,1C -> note_off pulse one cycle after the 1C byte, key_held=0.
- 22 ×3 -> oct_sel=6 (saturated, third press no-op). Then 42 -> note_in with note=0, octave=6. Then 1A ×8 -> oct_sel=0.
- Hold 1C, strobe 33 -> note_in, note=9, no note_off. Then F0,1C -> no note_off. Then F0,33 -> note_off.
- E0,75 and E0,F0,75 -> no outputs change, FSM back in IDLE. A following 23 -> note_in, note=4.
- Assert reset after F0 while 2B is held -> key_held=0, oct_sel=4. After release, strobe 2B -> note_in, note=5.

Source files
------------

// File: rtl/ps2_note_encoder_pkg.sv
// Shared constants for the PS/2 note path: scan codes, note encodings, FSM states, widths.
package ps2_synth_pkg;

  localparam int NOTE_W = 4;
  localparam int OCT_W  = 3;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_C       = 8'h1C;
  localparam logic [7:0] SC_CS      = 8'h1D;
  localparam logic [7:0] SC_D       = 8'h1B;
  localparam logic [7:0] SC_DS      = 8'h24;
  localparam logic [7:0] SC_E       = 8'h23;
  localparam logic [7:0] SC_F       = 8'h2B;
  localparam logic [7:0] SC_FS      = 8'h2C;
  localparam logic [7:0] SC_G       = 8'h34;
  localparam logic [7:0] SC_GS      = 8'h35;
  localparam logic [7:0] SC_A       = 8'h33;
  localparam logic [7:0] SC_AS      = 8'h3C;
  localparam logic [7:0] SC_B       = 8'h3B;
  localparam logic [7:0] SC_HI_C    = 8'h42;
  localparam logic [7:0] SC_OCT_DN  = 8'h1A;
  localparam logic [7:0] SC_OCT_UP  = 8'h22;

  localparam logic [NOTE_W-1:0] N_C  = 4'd0;
  localparam logic [NOTE_W-1:0] N_CS = 4'd1;
  localparam logic [NOTE_W-1:0] N_D  = 4'd2;
  localparam logic [NOTE_W-1:0] N_DS = 4'd3;
  localparam logic [NOTE_W-1:0] N_E  = 4'd4;
  localparam logic [NOTE_W-1:0] N_F  = 4'd5;
  localparam logic [NOTE_W-1:0] N_FS = 4'd6;
  localparam logic [NOTE_W-1:0] N_G  = 4'd7;
  localparam logic [NOTE_W-1:0] N_GS = 4'd8;
  localparam logic [NOTE_W-1:0] N_A  = 4'd9;
  localparam logic [NOTE_W-1:0] N_AS = 4'd10;
  localparam logic [NOTE_W-1:0] N_B  = 4'd11;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_BREAK     = 2'd1;
  localparam logic [1:0] ST_EXT       = 2'd2;
  localparam logic [1:0] ST_EXT_BREAK = 2'd3;

endpackage

// File: rtl/ps2_note_encoder_if.sv
// Byte-in / note-event-out bundle between the PS/2 receiver, the encoder and the ALU controller.
interface ps2_note_encoder_if;
  import ps2_synth_pkg::*;

  // scan_valid is a one-cycle strobe with no ready: the encoder accepts every byte,
  // including strobes on consecutive cycles. note_in / note_off are one-cycle pulses.
  logic [7:0]        scan_code;
  logic              scan_valid;
  logic              note_in;
  logic [NOTE_W-1:0] note;
  logic [OCT_W-1:0]  octave;
  logic              note_off;
  logic              key_held;
  logic [OCT_W-1:0]  oct_sel;
  logic [1:0]        fsm_state;

  modport master (
    output scan_code, scan_valid,
    input  note_in, note, octave, note_off, key_held, oct_sel, fsm_state
  );

  modport slave (
    input  scan_code, scan_valid,
    output note_in, note, octave, note_off, key_held, oct_sel, fsm_state
  );

endinterface

// File: rtl/ps2_note_encoder_keymap.sv
// Combinational decode of a set-2 make code into note / octave-key functions.
module ps2_keymap
  import ps2_synth_pkg::*;
(
  input  logic [7:0]        scan_code,
  output logic              is_note,
  output logic [NOTE_W-1:0] note,
  output logic              oct_bump,
  output logic              is_oct_up,
  output logic              is_oct_down
);

  always_comb begin
    is_note     = 1'b1;
    note        = N_C;
    oct_bump    = 1'b0;
    is_oct_up   = 1'b0;
    is_oct_down = 1'b0;
    case (scan_code)
      SC_C:      note = N_C;
      SC_CS:     note = N_CS;
      SC_D:      note = N_D;
      SC_DS:     note = N_DS;
      SC_E:      note = N_E;
      SC_F:      note = N_F;
      SC_FS:     note = N_FS;
      SC_G:      note = N_G;
      SC_GS:     note = N_GS;
      SC_A:      note = N_A;
      SC_AS:     note = N_AS;
      SC_B:      note = N_B;
      SC_HI_C:   oct_bump = 1'b1;
      SC_OCT_UP: begin is_note = 1'b0; is_oct_up = 1'b1; end
      SC_OCT_DN: begin is_note = 1'b0; is_oct_down = 1'b1; end
      default:   is_note = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_note_encoder.sv
// PS/2 byte stream to note events: make/break prefix FSM, held-key tracking, octave select.
module ps2_note_encoder
  import ps2_synth_pkg::*;
#(
  parameter int DEFAULT_OCTAVE = 4,
  parameter int MAX_OCTAVE     = 6
) (
  input  logic                clk,
  input  logic                reset,
  ps2_note_encoder_if.slave   bus
);

  localparam logic [OCT_W-1:0] OCT_DEF = OCT_W'(DEFAULT_OCTAVE);
  localparam logic [OCT_W-1:0] OCT_MAX = OCT_W'(MAX_OCTAVE);

  logic [1:0]        state;
  logic [7:0]        held_code;
  logic              key_held;
  logic              note_in;
  logic              note_off;
  logic [NOTE_W-1:0] note;
  logic [OCT_W-1:0]  octave;
  logic [OCT_W-1:0]  oct_sel;

  logic              km_is_note;
  logic [NOTE_W-1:0] km_note;
  logic              km_bump;
  logic              km_up;
  logic              km_down;
  logic [OCT_W-1:0]  oct_up_sat;
  logic [OCT_W-1:0]  oct_dn_sat;
  logic              held_match;

  ps2_keymap u_keymap (
    .scan_code   (bus.scan_code),
    .is_note     (km_is_note),
    .note        (km_note),
    .oct_bump    (km_bump),
    .is_oct_up   (km_up),
    .is_oct_down (km_down)
  );

  assign oct_up_sat = (oct_sel == OCT_MAX) ? OCT_MAX : oct_sel + OCT_W'(1);
  assign oct_dn_sat = (oct_sel == '0) ? '0 : oct_sel - OCT_W'(1);
  assign held_match = key_held && (bus.scan_code == held_code);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      held_code <= '0;
      key_held  <= 1'b0;
      note_in   <= 1'b0;
      note_off  <= 1'b0;
      note      <= N_C;
      octave    <= OCT_DEF;
      oct_sel   <= OCT_DEF;
    end else begin
      note_in  <= 1'b0;
      note_off <= 1'b0;
      if (bus.scan_valid) begin
        case (state)
          ST_IDLE: begin
            if (bus.scan_code == SC_BREAK) begin
              state <= ST_BREAK;
            end else if (bus.scan_code == SC_EXT) begin
              state <= ST_EXT;
            end else if (km_is_note) begin
              // A repeat of the held key is typematic; any other note steals the voice.
              if (!held_match) begin
                note_in   <= 1'b1;
                note      <= km_note;
                octave    <= km_bump ? oct_up_sat : oct_sel;
                key_held  <= 1'b1;
                held_code <= bus.scan_code;
              end
            end else if (km_up) begin
              oct_sel <= oct_up_sat;
            end else if (km_down) begin
              oct_sel <= oct_dn_sat;
            end
          end
          ST_BREAK: begin
            state <= ST_IDLE;
            if (held_match) begin
              note_off <= 1'b1;
              key_held <= 1'b0;
            end
          end
          ST_EXT:  state <= (bus.scan_code == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.note_in   = note_in;
  assign bus.note      = note;
  assign bus.octave    = octave;
  assign bus.note_off  = note_off;
  assign bus.key_held  = key_held;
  assign bus.oct_sel   = oct_sel;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_ps2_note_encoder.sv
// Bench for ps2_note_encoder: directed scenarios then random byte streams against a prefix-queue model.
module tb_ps2_note_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_note_encoder_if bus ();

  ps2_note_encoder #(.DEFAULT_OCTAVE(4), .MAX_OCTAVE(6)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scan code of each note, indexed by note number (C..B).
  logic [7:0] note_codes [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                  8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};

  // Model: pending prefix bytes, selected octave, held key and expected outputs.
  logic [7:0] prefix_q [$];
  logic [6:0] exp_q [$];
  int         m_oct;
  bit         m_held;
  logic [7:0] m_held_code;
  bit         exp_note_in, exp_note_off;
  int         exp_note, exp_octave;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int note_of(input logic [7:0] code);
    for (int i = 0; i < 12; i++) if (note_codes[i] == code) return i;
    return -1;
  endfunction

  function automatic int exp_state();
    if (prefix_q.size() == 0) return 0;
    if (prefix_q.size() == 2) return 3;
    return (prefix_q[0] == 8'hF0) ? 1 : 2;
  endfunction

  task automatic model_reset();
    prefix_q.delete();
    exp_q.delete();
    m_oct = 4; m_held = 0; m_held_code = 8'h00;
    exp_note_in = 0; exp_note_off = 0; exp_note = 0; exp_octave = 4;
  endtask

  task automatic model_make(input logic [7:0] code);
    int n, o;
    n = note_of(code);
    if (code == 8'h42) n = 0;
    if (n >= 0) begin
      o = (code == 8'h42) ? ((m_oct + 1 > 6) ? 6 : m_oct + 1) : m_oct;
      if (!(m_held && code == m_held_code)) begin
        exp_note_in = 1; exp_note = n; exp_octave = o;
        m_held = 1; m_held_code = code;
        exp_q.push_back({3'(o), 4'(n)});
      end
    end else if (code == 8'h22) begin
      m_oct = (m_oct >= 6) ? 6 : m_oct + 1;
    end else if (code == 8'h1A) begin
      m_oct = (m_oct <= 0) ? 0 : m_oct - 1;
    end
  endtask

  task automatic model_apply(input bit v, input logic [7:0] code);
    exp_note_in = 0; exp_note_off = 0;
    if (!v) return;
    if (prefix_q.size() == 0) begin
      if (code == 8'hF0 || code == 8'hE0) prefix_q.push_back(code);
      else model_make(code);
    end else if (prefix_q.size() == 1 && prefix_q[0] == 8'hF0) begin
      prefix_q.delete();
      if (m_held && code == m_held_code) begin exp_note_off = 1; m_held = 0; end
    end else if (prefix_q.size() == 1 && code == 8'hF0) begin
      prefix_q.push_back(code);
    end else begin
      prefix_q.delete();
    end
  endtask

  task automatic check_outputs();
    logic [6:0] ev;
    check("note_in",  bus.note_in,  exp_note_in);
    check("note_off", bus.note_off, exp_note_off);
    check("key_held", bus.key_held, m_held);
    check("note",     bus.note,     exp_note);
    check("octave",   bus.octave,   exp_octave);
    check("oct_sel",  bus.oct_sel,  m_oct);
    check("fsm",      bus.fsm_state, exp_state());
    if (exp_note_in && exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      check("event", {bus.octave, bus.note}, ev);
    end
  endtask

  // One clock: check last cycle's outcome, then present new input and advance the model.
  task automatic cycle(input bit v, input logic [7:0] code);
    @(negedge clk);
    check_outputs();
    bus.scan_valid = v;
    bus.scan_code  = code;
    model_apply(v, code);
  endtask

  task automatic send(input logic [7:0] code);
    cycle(1'b1, code);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    bus.scan_valid = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    check("rst_key_held", bus.key_held, 0);
    check("rst_oct_sel",  bus.oct_sel, 4);
    check("rst_fsm",      bus.fsm_state, 0);
    rst_n = 1;
  endtask

  logic [7:0] pool [20] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35, 8'h33,
                            8'h3C, 8'h3B, 8'h42, 8'h1A, 8'h22, 8'hF0, 8'hF0, 8'hE0, 8'h75, 8'h00};

  initial begin
    bus.scan_valid = 0;
    bus.scan_code  = 8'h00;
    model_reset();
    @(negedge clk);
    check("reset_note_in", bus.note_in, 0);
    check("reset_octave",  bus.octave, 4);
    check("reset_oct_sel", bus.oct_sel, 4);
    rst_n = 1;
    idle(2);

    // Trigger, typematic repeats, release.
    send(8'h1C); idle(1);
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C); idle(2);

    // Octave saturation up, high C, saturation down.
    send(8'h22); send(8'h22); send(8'h22); idle(1);
    check("oct_sat_hi", bus.oct_sel, 6);
    send(8'h42); idle(1);
    send(8'hF0); send(8'h42);
    for (int i = 0; i < 8; i++) send(8'h1A);
    idle(1);
    check("oct_sat_lo", bus.oct_sel, 0);
    send(8'h22); send(8'h22); send(8'h22); send(8'h22); idle(1);

    // Last-note priority: stale release ignored, current release honoured.
    send(8'h1C); send(8'h33); idle(1);
    send(8'hF0); send(8'h1C); idle(1);
    send(8'hF0); send(8'h33); idle(2);

    // Extended sequences have no effect.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(1);
    send(8'h23); idle(1);
    check("ext_then_e", bus.note, 4);

    // Reset while a break prefix is pending and a key is held.
    send(8'h2B); send(8'hF0);
    do_reset();
    idle(1);
    send(8'h2B); idle(1);
    check("post_rst_f", bus.note, 5);

    // Random byte streams with gaps and back-to-back strobes.
    for (int i = 0; i < 3000; i++) begin
      int k;
      logic [7:0] b;
      k = $urandom_range(0, 19);
      b = (k == 19) ? 8'($urandom_range(0, 255)) : pool[k];
      cycle(($urandom_range(0, 3) != 0), b);
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    idle(2);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
